out_pixel_packer: RTL

Downstream stage of `bilinear_core_scalar`. Consumes the core's scalar output-pixel writes (`wr_valid`/`wr_addr`/`wr_data`), packs four 8-bit pixels into little-endian 32-bit words, and buffers them in a small FIFO. Drains the words as a valid/ready stream with a frame-end marker. Replaces the flat output BRAM for DMA/streaming back-ends.

---
 rtl/out_pixel_packer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/out_pixel_packer.sv
// out_pixel_packer: packs scalar 8-bit pixel writes into little-endian 32-bit words,
// buffers them in a small word FIFO and drains them as a valid/ready stream with a
// frame-end marker.
// Optional feature: define OUT_PACKER_ADDR_CHECK_EN to compare wr_addr with the
// internal pixel counter and flag mismatches on addr_err (tied low otherwise).
module out_pixel_packer #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] out_w,
  input  logic [15:0] out_h,
  input  logic        wr_valid,
  input  logic [31:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        almost_full,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last,
  output logic        busy,
  output logic        frame_done,
  output logic        overflow,
  output logic        addr_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntAf   = CntW'(FIFO_DEPTH - 2);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        overflow_q, overflow_d;
  logic        addr_err_q, addr_err_d;

  // FIFO entry: {last, keep[3:0], data[31:0]}
  logic [36:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic [36:0]     head;

  logic        pix_acc, last_pix, word_done;
  logic        push, push_ok, pop;
  logic [1:0]  lane;
  logic [31:0] asm_wr;
  logic [3:0]  keep_wr;

  // Pixel lane insertion, FIFO push/pop decisions and occupancy.
  always_comb begin
    lane      = pix_cnt_q[1:0];
    pix_acc   = (state_q == StCollect) && wr_valid;
    last_pix  = (pix_cnt_q + 32'd1) == n_q;
    word_done = (lane == 2'd3) || last_pix;
    asm_wr    = asm_q;
    keep_wr   = 4'b0000;
    unique case (lane)
      2'd0: begin asm_wr[7:0]   = wr_data; keep_wr = 4'b0001; end
      2'd1: begin asm_wr[15:8]  = wr_data; keep_wr = 4'b0011; end
      2'd2: begin asm_wr[23:16] = wr_data; keep_wr = 4'b0111; end
      default: begin asm_wr[31:24] = wr_data; keep_wr = 4'b1111; end
    endcase
    pop     = m_valid && m_ready;
    push    = pix_acc && word_done;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push_ok = push && ((count_q != CntFull) || pop);
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Frame control next-state.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    pix_cnt_d    = pix_cnt_q;
    asm_d        = asm_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    addr_err_d   = addr_err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          n_d        = {16'd0, out_w} * {16'd0, out_h};
          pix_cnt_d  = '0;
          asm_d      = '0;
          overflow_d = 1'b0;
          addr_err_d = 1'b0;
          if (n_d == 32'd0) begin
            // Empty frame: report completion without ever collecting.
            frame_done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (wr_valid) begin
          pix_cnt_d = pix_cnt_q + 32'd1;
          // Clear after completion so unfilled lanes of a short last word read as zero.
          asm_d     = word_done ? '0 : asm_wr;
          if (push && !push_ok) begin
            overflow_d = 1'b1;
          end
`ifdef OUT_PACKER_ADDR_CHECK_EN
          if (wr_addr != pix_cnt_q) begin
            addr_err_d = 1'b1;
          end
`endif
          if (last_pix) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (count_d == '0) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Frame control state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      n_q          <= '0;
      pix_cnt_q    <= '0;
      asm_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      pix_cnt_q    <= pix_cnt_d;
      asm_q        <= asm_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {last_pix, keep_wr, asm_wr};
    end
  end

`ifndef OUT_PACKER_ADDR_CHECK_EN
  logic unused_wr_addr;
  assign unused_wr_addr = ^wr_addr;
`endif

  assign head        = mem_q[rd_ptr_q];
  assign m_valid     = (count_q != '0);
  assign m_data      = m_valid ? head[31:0]  : '0;
  assign m_keep      = m_valid ? head[35:32] : '0;
  assign m_last      = m_valid && head[36];
  assign almost_full = (count_q >= CntAf);
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign addr_err    = addr_err_q;

endmodule
